// File: rtl/ps2_kbd_tx_if.sv
// Scancode byte handshake between a producer and the PS/2 keyboard transmitter.
interface ps2_kbd_tx_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: 8-deep scancode FIFO feeding an 11-bit odd-parity serialiser.
// Optional macro PS2_TX_ERRINJ_EN adds err_inj, which inverts the parity bit of a frame.
module ps2_kbd_tx #(
  parameter int CLK_DIV = 8,
  parameter int GAP     = 16
) (
  input  logic        clock,
  input  logic        reset_n,
`ifdef PS2_TX_ERRINJ_EN
  input  logic        err_inj,
`endif
  ps2_kbd_tx_if.slave in_bus,
  output logic        ps2_clk,
  output logic        ps2_data,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  localparam logic [8:0] HC_HIGH  = 9'(CLK_DIV);
  localparam logic [8:0] HC_LAST  = 9'(2 * CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  state_t      state_reg;
  logic [7:0]  mem [8];
  logic [2:0]  wr_ptr_reg;
  logic [2:0]  rd_ptr_reg;
  logic [3:0]  count_reg;
  logic [9:0]  frame_reg;   // {stop, parity, data}; start bit is emitted on load
  logic [3:0]  bit_idx_reg;
  logic [8:0]  hc_reg;
  logic [7:0]  gap_cnt_reg;
  logic        push;
  logic        pop;
  logic        inj;
  logic [7:0]  head;

  assign in_bus.in_ready = (count_reg != 4'd8);
  assign push            = in_bus.in_valid && in_bus.in_ready;
  assign pop             = (state_reg == ST_IDLE) && (count_reg != 4'd0);
  assign busy            = (count_reg != 4'd0) || (state_reg != ST_IDLE);
  assign head            = mem[rd_ptr_reg];

`ifdef PS2_TX_ERRINJ_EN
  assign inj = err_inj;
`else
  assign inj = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_bus.in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_reg <= 3'd0;
      rd_ptr_reg <= 3'd0;
      count_reg  <= 4'd0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 3'd1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 3'd1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 4'd1;
        2'b01:   count_reg <= count_reg - 4'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      frame_reg   <= 10'h3FF;
      bit_idx_reg <= 4'd0;
      hc_reg      <= 9'd0;
      gap_cnt_reg <= 8'd0;
      frame_cnt   <= 16'd0;
      ps2_clk     <= 1'b1;
      ps2_data    <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b1;
          if (pop) begin
            frame_reg   <= {1'b1, (~^head) ^ inj, head};
            bit_idx_reg <= 4'd0;
            hc_reg      <= 9'd0;
            ps2_data    <= 1'b0;
            state_reg   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (hc_reg == HC_LAST) begin
            hc_reg  <= 9'd0;
            ps2_clk <= 1'b1;
            if (bit_idx_reg == 4'd10) begin
              ps2_data    <= 1'b1;
              gap_cnt_reg <= 8'd0;
              frame_cnt   <= frame_cnt + 16'd1;
              state_reg   <= ST_GAP;
            end else begin
              // Data only moves at the start of a high half, so receivers see it settled.
              bit_idx_reg <= bit_idx_reg + 4'd1;
              ps2_data    <= frame_reg[0];
              frame_reg   <= {1'b1, frame_reg[9:1]};
            end
          end else begin
            hc_reg  <= hc_reg + 9'd1;
            ps2_clk <= (hc_reg + 9'd1) < HC_HIGH;
          end
        end
        ST_GAP: begin
          ps2_clk     <= 1'b1;
          ps2_data    <= 1'b1;
          gap_cnt_reg <= gap_cnt_reg + 8'd1;
          if (gap_cnt_reg == GAP_LAST) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Randomised bench for ps2_kbd_tx with a behavioural PS/2 receiver and a byte scoreboard.
module tb_ps2_kbd_tx;
  localparam int CLK_DIV = 4;
  localparam int GAP     = 16;
  localparam int FRAME_GAP = 2 * CLK_DIV + GAP + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        err_inj = 1'b0;
  logic        ps2_clk, ps2_data, busy;
  logic [15:0] frame_cnt;

  ps2_kbd_tx_if ifc ();

  ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
    .clock     (clk),
    .reset_n   (reset_n),
`ifdef PS2_TX_ERRINJ_EN
    .err_inj   (err_inj),
`endif
    .in_bus    (ifc),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int falls = 0;
  int last_fall = -1;
  int spacing_err = 0;
  int hold_err = 0;
  int drops = 0;
  int rx_n = 0;
  int exp_frames = 0;
  logic [10:0] rx_bits, last_bits;
  logic prev_clk = 1'b1, prev_data = 1'b1;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int gap_q[$];

  always @(posedge clk) cyc++;

  // Behavioural PS/2 receiver: sample data on each falling ps2_clk edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      rx_n = 0;
      last_fall = -1;
      prev_clk = 1'b1;
      prev_data = 1'b1;
    end else begin
      if (prev_clk && !ps2_clk) begin
        falls++;
        if (rx_n > 0 && cyc - last_fall != 2 * CLK_DIV) spacing_err++;
        if (rx_n == 0 && last_fall >= 0) gap_q.push_back(cyc - last_fall);
        last_fall = cyc;
        rx_bits[rx_n] = ps2_data;
        rx_n++;
        if (rx_n == 11) begin
          rx_n = 0;
          last_bits = rx_bits;
          if (!rx_bits[0] && rx_bits[10] && ($countones(rx_bits[9:1]) % 2 == 1)) begin
            rx_q.push_back(rx_bits[8:1]);
            $display("RX byte %02h at cycle %0d", rx_bits[8:1], cyc);
          end else begin
            drops++;
            $display("RX frame dropped bits %011b at cycle %0d", rx_bits, cyc);
          end
        end
      end
      if (!prev_clk && !ps2_clk && ps2_data !== prev_data) hold_err++;
      prev_clk = ps2_clk;
      prev_data = ps2_data;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data = b;
    while (ifc.in_ready !== 1'b1 && t < 2000) begin step(); t++; end
    step();
    ifc.in_valid = 1'b0;
    exp_q.push_back(b);
    exp_frames++;
    $display("PUSH byte %02h at cycle %0d", b, cyc);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((frame_cnt !== 16'(exp_frames) || busy !== 1'b0) && t < 20000) begin step(); t++; end
    checks++;
    if (frame_cnt !== 16'(exp_frames) || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done frame_cnt=%0d busy=%b required frame_cnt=%0d busy=0",
               name, frame_cnt, busy, exp_frames);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data = 8'h00;
    repeat (3) step();
    checks++;
    if ({ps2_clk, ps2_data, ifc.in_ready, busy} !== 4'b1110 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset clk/data/ready/busy=%b frame_cnt=%0d required 1110 and 0",
               {ps2_clk, ps2_data, ifc.in_ready, busy}, frame_cnt);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_known_frame();
    logic [7:0]  d = 8'h1C;
    logic [10:0] expb;
    int sp0 = spacing_err;
    expb = {1'b1, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
    rx_q.delete(); exp_q.delete();
    push_byte(d);
    wait_done("known");
    checks++;
    if (last_bits !== expb) begin
      errors++;
      $display("FAIL known_bits got %011b required %011b", last_bits, expb);
    end
    checks++;
    if (last_bits[9] !== 1'b0) begin
      errors++;
      $display("FAIL known_parity got %b required 0", last_bits[9]);
    end
    checks++;
    if (spacing_err != sp0) begin
      errors++;
      $display("FAIL known_spacing bad fall spacings %0d required 0", spacing_err - sp0);
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL known_frame_cnt got %0d required 1", frame_cnt);
    end
  endtask

  task automatic test_zero();
    rx_q.delete(); exp_q.delete();
    push_byte(8'h00);
    wait_done("zero");
    checks++;
    if (last_bits[9] !== 1'b1) begin
      errors++;
      $display("FAIL zero_parity got %b required 1", last_bits[9]);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h00) begin
      errors++;
      $display("FAIL zero_rx got size %0d byte %02h required one byte 00",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hXX);
    end
  endtask

`ifdef PS2_TX_ERRINJ_EN
  task automatic test_errinj();
    int d0 = drops;
    logic [7:0] b = 8'($urandom);
    rx_q.delete(); exp_q.delete();
    err_inj = 1'b1;
    push_byte(8'h1C);
    repeat (3) step();
    err_inj = 1'b0;
    wait_done("errinj");
    checks++;
    if (last_bits[9] !== 1'b1 || drops != d0 + 1 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL errinj_drop parity=%b drops=%0d rx=%0d required parity 1 one drop rx 0",
               last_bits[9], drops - d0, rx_q.size());
    end
    push_byte(b);
    wait_done("errinj_next");
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== b) begin
      errors++;
      $display("FAIL errinj_next rx size %0d required byte %02h", rx_q.size(), b);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] b[10];
    int t = 0;
    rx_q.delete(); exp_q.delete();
    foreach (b[i]) b[i] = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data = b[i];
      checks++;
      if (ifc.in_ready !== (i < 9)) begin
        errors++;
        $display("FAIL b2b_ready cycle %0d got %b required %b", i, ifc.in_ready, i < 9);
      end
      if (i < 9) begin
        exp_q.push_back(b[i]);
        exp_frames++;
      end
      step();
    end
    while (ifc.in_ready !== 1'b1 && t < 2000) begin step(); t++; end
    step();
    ifc.in_valid = 1'b0;
    exp_q.push_back(b[9]);
    exp_frames++;
    wait_done("b2b");
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_order frame %0d got %02h required %02h",
                 i, (i < rx_q.size()) ? rx_q[i] : 8'hXX, exp_q[i]);
      end
    end
    for (int i = gap_q.size() - 9; i < gap_q.size(); i++) begin
      checks++;
      if (gap_q[i] != FRAME_GAP) begin
        errors++;
        $display("FAIL b2b_gap got %0d cycles between falls required %0d", gap_q[i], FRAME_GAP);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int f0 = falls;
    int t = 0;
    rx_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    while (falls - f0 < 6 && t < 2000) begin step(); t++; end
    reset_n = 1'b0;
    step();
    checks++;
    if ({ps2_clk, ps2_data, busy} !== 3'b110 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midreset clk/data/busy=%b frame_cnt=%0d required 110 and 0",
               {ps2_clk, ps2_data, busy}, frame_cnt);
    end
    reset_n = 1'b1;
    f0 = falls;
    repeat (300) step();
    checks++;
    if (falls != f0 || rx_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet falls=%0d rx=%0d busy=%b required 0 0 0",
               falls - f0, rx_q.size(), busy);
    end
    exp_frames = 0;
    rx_n = 0;
    exp_q.delete();
  endtask

  task automatic test_wrap();
    rx_q.delete(); exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      push_byte(8'($urandom));
      wait_done("wrap");
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL wrap_order frame %0d got %02h required %02h",
                 i, (i < rx_q.size()) ? rx_q[i] : 8'hXX, exp_q[i]);
      end
    end
    checks++;
    if (frame_cnt !== 16'd20) begin
      errors++;
      $display("FAIL wrap_frame_cnt got %0d required 20", frame_cnt);
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL data_hold data changed while ps2_clk low %0d times required 0", hold_err);
    end
  endtask

  initial begin
    test_reset();
    test_known_frame();
    test_zero();
`ifdef PS2_TX_ERRINJ_EN
    test_errinj();
`endif
    test_back_to_back();
    test_reset_mid_frame();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
